vm2002_change_dispenser: RTL and testbench

VM2002_CHANGE_DISPENSER -- requirements
Module: vm2002_change_dispenser

---
 rtl/vm2002_change_dispenser_if.sv | 31 +++
 rtl/vm2002_change_dispenser.sv | 143 ++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vm2002_change_dispenser_if.sv
// Handshake and status bundle between the change dispenser and its host/coin mechanism.
interface vm2002_change_dispenser_if;
    logic       change_req;
    logic [7:0] balance;
    logic       coin_ack;
    logic       refill;
    logic [1:0] refill_coin;
    logic [3:0] refill_count;
    logic       coin_valid;
    logic [1:0] coin_out;
    logic       change_busy;
    logic       change_done;
    logic       change_short;
    logic       jam;
    logic [7:0] remaining;
    logic [5:0] nickel_cnt;
    logic [5:0] dime_cnt;
    logic [5:0] quarter_cnt;

    modport slave (
        input  change_req, balance, coin_ack, refill, refill_coin, refill_count,
        output coin_valid, coin_out, change_busy, change_done, change_short, jam,
               remaining, nickel_cnt, dime_cnt, quarter_cnt
    );

    modport master (
        output change_req, balance, coin_ack, refill, refill_coin, refill_count,
        input  coin_valid, coin_out, change_busy, change_done, change_short, jam,
               remaining, nickel_cnt, dime_cnt, quarter_cnt
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Greedy coin change dispenser with per-tube inventory, supplier refill and ack-timeout jam detection.
//
// state    | meaning
// IDLE     | waiting for change_req; refills accepted here only
// SELECT   | one-cycle pick of the largest coin that fits and is in stock
// WAIT_ACK | coin presented, waiting for coin_ack or ack timeout
// DONE     | one-cycle change_done pulse
// SHORT    | one-cycle change_short pulse (out of coins or jam)
module vm2002_change_dispenser #(
    parameter int TUBE_MAX    = 63,
    parameter int INIT_COUNT  = 20,
    parameter int ACK_TIMEOUT = 255
) (
    input logic                      clk,
    input logic                      hrst,
    vm2002_change_dispenser_if.slave bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        SHORT    = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] ack_timer;
    logic [1:0]    sel_coin;

    function automatic logic [7:0] coin_value(input logic [1:0] c);
        case (c)
            2'd1:    return 8'd5;
            2'd2:    return 8'd10;
            2'd3:    return 8'd25;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [5:0] refill_sat(input logic [5:0] cnt, input logic [3:0] add);
        logic [6:0] sum;
        sum = {1'b0, cnt} + {3'b000, add};
        if (sum > 7'(TUBE_MAX))
            return 6'(TUBE_MAX);
        return sum[5:0];
    endfunction

    // Remaining is always a multiple of 5, so a nickel fits whenever it is nonzero.
    always_comb begin
        sel_coin = 2'd0;
        if (bus.remaining >= 8'd25 && bus.quarter_cnt != 6'd0)
            sel_coin = 2'd3;
        else if (bus.remaining >= 8'd10 && bus.dime_cnt != 6'd0)
            sel_coin = 2'd2;
        else if (bus.remaining >= 8'd5 && bus.nickel_cnt != 6'd0)
            sel_coin = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (hrst) begin
            state            <= IDLE;
            ack_timer        <= '0;
            bus.coin_valid   <= 1'b0;
            bus.coin_out     <= 2'd0;
            bus.change_busy  <= 1'b0;
            bus.change_done  <= 1'b0;
            bus.change_short <= 1'b0;
            bus.jam          <= 1'b0;
            bus.remaining    <= 8'd0;
            bus.nickel_cnt   <= 6'(INIT_COUNT);
            bus.dime_cnt     <= 6'(INIT_COUNT);
            bus.quarter_cnt  <= 6'(INIT_COUNT);
        end else begin
            bus.change_done  <= 1'b0;
            bus.change_short <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.refill) begin
                        case (bus.refill_coin)
                            2'd1:    bus.nickel_cnt  <= refill_sat(bus.nickel_cnt, bus.refill_count);
                            2'd2:    bus.dime_cnt    <= refill_sat(bus.dime_cnt, bus.refill_count);
                            2'd3:    bus.quarter_cnt <= refill_sat(bus.quarter_cnt, bus.refill_count);
                            default: ;
                        endcase
                    end
                    if (bus.change_req) begin
                        bus.remaining   <= bus.balance - (bus.balance % 8'd5);
                        bus.jam         <= 1'b0;
                        bus.change_busy <= 1'b1;
                        state           <= SELECT;
                    end
                end
                SELECT: begin
                    if (bus.remaining == 8'd0) begin
                        bus.change_done <= 1'b1;
                        state           <= DONE;
                    end else if (sel_coin == 2'd0) begin
                        bus.change_short <= 1'b1;
                        state            <= SHORT;
                    end else begin
                        bus.coin_valid <= 1'b1;
                        bus.coin_out   <= sel_coin;
                        ack_timer      <= TW'(ACK_TIMEOUT - 1);
                        state          <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.coin_ack) begin
                        bus.coin_valid <= 1'b0;
                        bus.coin_out   <= 2'd0;
                        bus.remaining  <= bus.remaining - coin_value(bus.coin_out);
                        case (bus.coin_out)
                            2'd1:    bus.nickel_cnt  <= bus.nickel_cnt - 6'd1;
                            2'd2:    bus.dime_cnt    <= bus.dime_cnt - 6'd1;
                            2'd3:    bus.quarter_cnt <= bus.quarter_cnt - 6'd1;
                            default: ;
                        endcase
                        state <= SELECT;
                    end else if (ack_timer == '0) begin
                        bus.coin_valid   <= 1'b0;
                        bus.coin_out     <= 2'd0;
                        bus.jam          <= 1'b1;
                        bus.change_short <= 1'b1;
                        state            <= SHORT;
                    end else begin
                        ack_timer <= ack_timer - TW'(1);
                    end
                end
                DONE, SHORT: begin
                    bus.change_busy <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    bus.coin_valid  <= 1'b0;
                    bus.coin_out    <= 2'd0;
                    bus.change_busy <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Directed bench: default-parameter dispenser plus an empty-tube (INIT_COUNT=0) instance.
module tb_vm2002_change_dispenser;
    logic clk = 1'b0;
    logic hrst;
    int checks = 0;
    int errors = 0;

    vm2002_change_dispenser_if a();
    vm2002_change_dispenser_if b();

    vm2002_change_dispenser dut_a (.clk(clk), .hrst(hrst), .bus(a));
    vm2002_change_dispenser #(.INIT_COUNT(0)) dut_b (.clk(clk), .hrst(hrst), .bus(b));

    always #5 clk = ~clk;

    bit         sel_b = 1'b0;
    logic       m_valid, m_done, m_short;
    logic [1:0] m_out;
    always_comb begin
        m_valid = sel_b ? b.coin_valid   : a.coin_valid;
        m_out   = sel_b ? b.coin_out     : a.coin_out;
        m_done  = sel_b ? b.change_done  : a.change_done;
        m_short = sel_b ? b.change_short : a.change_short;
    end

    logic [1:0] coin_log[$];
    bit         got_done, got_short;
    int         end_cyc, valid_cyc, unstable;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ack(input logic v);
        if (sel_b) b.coin_ack = v;
        else       a.coin_ack = v;
    endtask

    // Steps until change_done/change_short, acking every presented coin when ack_en.
    task automatic run_until_end(input int max_cycles, input bit ack_en);
        logic       prev_valid;
        logic [1:0] prev_out;
        coin_log.delete();
        got_done   = 1'b0;
        got_short  = 1'b0;
        end_cyc    = -1;
        valid_cyc  = 0;
        unstable   = 0;
        prev_valid = 1'b0;
        prev_out   = 2'd0;
        for (int c = 1; c <= max_cycles; c++) begin
            if (m_valid) begin
                valid_cyc++;
                if (prev_valid && m_out != prev_out) unstable++;
                if (ack_en) coin_log.push_back(m_out);
            end
            prev_valid = m_valid;
            prev_out   = m_out;
            drive_ack(m_valid && ack_en);
            step();
            if (m_done || m_short) begin
                got_done  = m_done;
                got_short = m_short;
                end_cyc   = c;
                break;
            end
        end
        drive_ack(1'b0);
    endtask

    task automatic request(input logic [7:0] amount);
        if (sel_b) begin b.balance = amount; b.change_req = 1'b1; end
        else       begin a.balance = amount; a.change_req = 1'b1; end
        step();
        a.change_req = 1'b0;
        b.change_req = 1'b0;
    endtask

    initial begin
        hrst = 1'b1;
        {a.change_req, a.coin_ack, a.refill} = 3'b000;
        {b.change_req, b.coin_ack, b.refill} = 3'b000;
        a.balance = 8'd0; a.refill_coin = 2'd0; a.refill_count = 4'd0;
        b.balance = 8'd0; b.refill_coin = 2'd0; b.refill_count = 4'd0;
        step();
        step();
        chk("rst_quarter", a.quarter_cnt, 20);
        chk("rst_dime", a.dime_cnt, 20);
        chk("rst_nickel", a.nickel_cnt, 20);
        chk("rst_outputs", {a.coin_valid, a.coin_out, a.change_busy, a.change_done,
                            a.change_short, a.jam, a.remaining}, 0);
        chk("rst_b_counts", {b.quarter_cnt, b.dime_cnt, b.nickel_cnt}, 0);
        hrst = 1'b0;
        step();

        // 65c with immediate acks: 25,25,10,5
        request(8'd65);
        chk("65_busy", a.change_busy, 1);
        chk("65_remaining_captured", a.remaining, 65);
        chk("65_no_coin_in_select", a.coin_valid, 0);
        run_until_end(60, 1'b1);
        chk("65_done", got_done, 1);
        chk("65_short", got_short, 0);
        chk("65_ncoins", coin_log.size(), 4);
        chk("65_coin0", coin_log[0], 3);
        chk("65_coin1", coin_log[1], 3);
        chk("65_coin2", coin_log[2], 2);
        chk("65_coin3", coin_log[3], 1);
        chk("65_end_cycle", end_cyc, 9);
        chk("65_counts", {a.quarter_cnt, a.dime_cnt, a.nickel_cnt}, {6'd18, 6'd19, 6'd19});
        chk("65_remaining", a.remaining, 0);
        step();
        chk("65_done_one_cycle", a.change_done, 0);
        chk("65_idle", a.change_busy, 0);

        // zero balance: done at N+2, no coin
        request(8'd0);
        run_until_end(10, 1'b1);
        chk("0_done", got_done, 1);
        chk("0_done_latency", end_cyc, 1);
        chk("0_no_coin", valid_cyc, 0);
        step();

        // 17c truncates to 15c: dime then nickel
        request(8'd17);
        chk("17_truncated", a.remaining, 15);
        run_until_end(40, 1'b1);
        chk("17_ncoins", coin_log.size(), 2);
        chk("17_coin0", coin_log[0], 2);
        chk("17_coin1", coin_log[1], 1);
        chk("17_counts", {a.quarter_cnt, a.dime_cnt, a.nickel_cnt}, {6'd18, 6'd18, 6'd18});
        step();

        // 25c never acked: timeout after 255 presented cycles
        request(8'd25);
        run_until_end(400, 1'b0);
        chk("to_short", got_short, 1);
        chk("to_done", got_done, 0);
        chk("to_valid_cycles", valid_cyc, 255);
        chk("to_coin_stable", unstable, 0);
        chk("to_jam", a.jam, 1);
        chk("to_remaining", a.remaining, 25);
        chk("to_quarter", a.quarter_cnt, 18);
        chk("to_valid_dropped", a.coin_valid, 0);
        a.coin_ack = 1'b1;
        step();
        a.coin_ack = 1'b0;
        chk("ack_idle_ignored", {a.remaining, a.quarter_cnt}, {8'd25, 6'd18});
        chk("to_short_one_cycle", a.change_short, 0);
        chk("jam_sticky", a.jam, 1);
        request(8'd0);
        chk("jam_cleared", a.jam, 0);
        run_until_end(10, 1'b1);
        step();

        // refill saturation and ignore rules
        a.refill = 1'b1; a.refill_coin = 2'd3; a.refill_count = 4'd15; step();
        a.refill_count = 4'd15; step();
        a.refill_count = 4'd12; step();
        chk("refill_to_60", a.quarter_cnt, 60);
        a.refill_count = 4'd15; step();
        chk("refill_sat_63", a.quarter_cnt, 63);
        a.refill_coin = 2'd0; a.refill_count = 4'd5; step();
        chk("refill_coin0_ignored", {a.quarter_cnt, a.dime_cnt, a.nickel_cnt},
            {6'd63, 6'd18, 6'd18});
        a.refill = 1'b0;
        request(8'd25);
        a.refill = 1'b1; a.refill_coin = 2'd3; a.refill_count = 4'd15;
        step();
        chk("refill_busy_ignored", a.quarter_cnt, 63);
        step();
        a.refill = 1'b0;
        run_until_end(20, 1'b1);
        chk("busy_refill_dispense", a.quarter_cnt, 62);
        step();

        // empty tubes: refill 2 dimes with the request, 30c -> 10,10 then short
        sel_b = 1'b1;
        b.refill = 1'b1; b.refill_coin = 2'd2; b.refill_count = 4'd2;
        request(8'd30);
        b.refill = 1'b0;
        chk("b_refill_same_cycle", b.dime_cnt, 2);
        run_until_end(40, 1'b1);
        chk("b_short", got_short, 1);
        chk("b_ncoins", coin_log.size(), 2);
        chk("b_coin0", coin_log[0], 2);
        chk("b_coin1", coin_log[1], 2);
        chk("b_remaining", b.remaining, 10);
        chk("b_dime", b.dime_cnt, 0);
        chk("b_jam", b.jam, 0);
        step();
        chk("b_remaining_held", b.remaining, 10);
        sel_b = 1'b0;

        // request during WAIT_ACK is dropped, then hard reset mid-dispense
        request(8'd65);
        step();
        chk("mid_coin", {a.coin_valid, a.coin_out}, {1'b1, 2'd3});
        a.balance = 8'd5; a.change_req = 1'b1;
        step();
        a.change_req = 1'b0;
        chk("req_in_wait_ignored", a.remaining, 65);
        chk("mid_coin_held", {a.coin_valid, a.coin_out}, {1'b1, 2'd3});
        a.coin_ack = 1'b1;
        step();
        a.coin_ack = 1'b0;
        chk("mid_after_ack", a.remaining, 40);
        step();
        hrst = 1'b1;
        a.change_req = 1'b1; a.coin_ack = 1'b1;
        a.refill = 1'b1; a.refill_coin = 2'd1; a.refill_count = 4'd9;
        step();
        {a.change_req, a.coin_ack, a.refill} = 3'b000;
        hrst = 1'b0;
        chk("hrst_counts", {a.quarter_cnt, a.dime_cnt, a.nickel_cnt}, {6'd20, 6'd20, 6'd20});
        chk("hrst_outputs", {a.coin_valid, a.coin_out, a.change_busy, a.change_done,
                             a.change_short, a.jam, a.remaining}, 0);
        step();
        step();
        chk("hrst_no_pulse_idle", {a.change_busy, a.change_done, a.change_short, a.coin_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
